// File: rtl/keypad_cmd_pkg.sv
// Shared definitions for the keypad command path: key codes, command byte
// field positions, constant values and the key-to-command mapping function.
package keypad_cmd_pkg;

    // Key codes understood by the encoder. Codes outside this set are
    // accepted by the debouncer but reported as key_err.
    localparam logic [3:0] KEY_STOP     = 4'd4;
    localparam logic [3:0] KEY_LOW      = 4'd5;
    localparam logic [3:0] KEY_HIGH     = 4'd6;
    localparam logic [3:0] KEY_LEFT     = 4'd8;
    localparam logic [3:0] KEY_STRAIGHT = 4'd9;
    localparam logic [3:0] KEY_RIGHT    = 4'd10;
    localparam logic [3:0] KEY_MODE     = 4'd12;
    localparam logic [3:0] KEY_DIR      = 4'd13;
    localparam logic [3:0] KEY_RESET    = 4'd14;

    // Command byte field positions.
    localparam int SPEED_LSB = 0;
    localparam int SPEED_MSB = 1;
    localparam int STEER_LSB = 2;
    localparam int STEER_MSB = 3;
    localparam int DIR_BIT   = 4;
    localparam int MODE_BIT  = 5;
    localparam int CHECK_LSB = 6;
    localparam int CHECK_MSB = 7;

    // Field encodings.
    localparam logic [1:0] SPEED_STOP     = 2'b00;
    localparam logic [1:0] SPEED_LOW      = 2'b01;
    localparam logic [1:0] SPEED_HIGH     = 2'b10;
    localparam logic [1:0] STEER_STRAIGHT = 2'b00;
    localparam logic [1:0] STEER_RIGHT    = 2'b01;
    localparam logic [1:0] STEER_LEFT     = 2'b10;

    // Check bits are fixed so the receiver can frame-check every byte.
    localparam logic [1:0] CHECK_BITS  = 2'b10;
    localparam logic [7:0] CMD_DEFAULT = 8'b1000_0000;

    // Debounce FSM states; visible by name in waveforms and to checkers.
    typedef enum logic [1:0] {
        DB_IDLE  = 2'd0,
        DB_COUNT = 2'd1,
        DB_HELD  = 2'd2
    } debounce_state_t;

    // Result of applying one key to the current command byte.
    typedef struct packed {
        logic [7:0] command;
        logic       mapped;
    } key_result_t;

    // Apply a 4-bit key code to a command byte. Unmapped codes leave the
    // byte untouched and clear the mapped flag. The check bits are forced
    // on every path so no key can ever corrupt them.
    function automatic key_result_t apply_key(input logic [7:0] cmd,
                                              input logic [3:0] code);
        key_result_t r;
        r.command = cmd;
        r.mapped  = 1'b1;
        case (code)
            KEY_STOP:     r.command[SPEED_MSB:SPEED_LSB] = SPEED_STOP;
            KEY_LOW:      r.command[SPEED_MSB:SPEED_LSB] = SPEED_LOW;
            KEY_HIGH:     r.command[SPEED_MSB:SPEED_LSB] = SPEED_HIGH;
            KEY_LEFT:     r.command[STEER_MSB:STEER_LSB] = STEER_LEFT;
            KEY_STRAIGHT: r.command[STEER_MSB:STEER_LSB] = STEER_STRAIGHT;
            KEY_RIGHT:    r.command[STEER_MSB:STEER_LSB] = STEER_RIGHT;
            KEY_MODE:     r.command[MODE_BIT] = ~cmd[MODE_BIT];
            KEY_DIR:      r.command[DIR_BIT]  = ~cmd[DIR_BIT];
            KEY_RESET:    r.command = CMD_DEFAULT;
            default: begin
                r.command = cmd;
                r.mapped  = 1'b0;
            end
        endcase
        r.command[CHECK_MSB:CHECK_LSB] = CHECK_BITS;
        return r;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchroniser plus IDLE/COUNT/HELD debouncer for an asynchronous level.
// Produces a single accept pulse per press once the synchronised level has
// been high for DEBOUNCE consecutive cycles; holding the input gives no
// auto-repeat. The accept pulse is combinational from registered state and
// lines up with the clock edge on which the count reaches DEBOUNCE.
// SYNC_STAGES must be at least 2 and DEBOUNCE at least 1.
module key_debounce
    import keypad_cmd_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 20
) (
    input  logic clk_10k,
    input  logic rst,
    input  logic din,
    output logic accept
);

    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE);

    logic [SYNC_STAGES-1:0] sync;
    logic                   vs;
    debounce_state_t        state;
    debounce_state_t        state_next;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       count_next;

    assign vs = sync[SYNC_STAGES-1];

    // Shift the asynchronous level through the synchroniser chain
    always_ff @(posedge clk_10k or posedge rst) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
        end
    end

    // Debounce state and counter registers
    always_ff @(posedge clk_10k or posedge rst) begin
        if (rst) begin
            state <= DB_IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Next-state logic: count consecutive high samples, fire once, then wait for release
    always_comb begin
        state_next = state;
        count_next = count;
        accept     = 1'b0;
        case (state)
            DB_IDLE: begin
                if (vs) begin
                    count_next = CNT_ONE;
                    if (CNT_ONE == CNT_DONE) begin
                        accept     = 1'b1;
                        state_next = DB_HELD;
                    end else begin
                        state_next = DB_COUNT;
                    end
                end
            end
            DB_COUNT: begin
                if (!vs) begin
                    state_next = DB_IDLE;
                end else begin
                    count_next = count + CNT_ONE;
                    if (count_next == CNT_DONE) begin
                        accept     = 1'b1;
                        state_next = DB_HELD;
                    end
                end
            end
            DB_HELD: begin
                if (!vs) begin
                    state_next = DB_IDLE;
                end
            end
            default: begin
                state_next = DB_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/keypad_command_encoder.sv
// Keypad command encoder: debounces the keypad valid level, applies each
// accepted key to the vehicle command byte and hands updated bytes to the
// serial transmitter.
//
// Handshake: pending means a byte is waiting. On any edge where pending and
// tx_ready are both high, send pulses for one cycle and pending clears;
// command is stable whenever send is high. tx_ready low simply holds pending.
// Several accepts before the transmitter is ready coalesce into a single
// send of the newest byte. If an accept lands on the same edge as a send,
// that send belongs to the earlier update and pending is raised again so the
// new byte gets a send of its own. A keepalive counter re-raises pending
// every KEEPALIVE cycles without a send (KEEPALIVE = 0 disables it).
module keypad_command_encoder
    import keypad_cmd_pkg::*;
#(
    parameter int KEY_W       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 20,
    parameter int KEEPALIVE   = 5000
) (
    input  logic             clk_10k,
    input  logic             rst,
    input  logic [KEY_W-1:0] key,
    input  logic             key_valid,
    input  logic             tx_ready,
    output logic [7:0]       command,
    output logic             send,
    output logic             key_err,
    output logic             pending
);

    logic        accept;
    logic        key_in_range;
    logic        key_mapped;
    logic        accept_mapped;
    logic        send_now;
    logic        ka_fire;
    key_result_t decoded;

    key_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEBOUNCE    (DEBOUNCE)
    ) u_debounce (
        .clk_10k (clk_10k),
        .rst     (rst),
        .din     (key_valid),
        .accept  (accept)
    );

    // Decode the key against the current byte; wide codes of 16 and up are unmapped
    always_comb begin
        key_in_range  = ({1'b0, key} < (KEY_W + 1)'(16));
        decoded       = apply_key(command, key[3:0]);
        key_mapped    = key_in_range && decoded.mapped;
        accept_mapped = accept && key_mapped;
        send_now      = pending && tx_ready;
    end

    // Keepalive timer: restarts on every send and raises pending when it expires
    if (KEEPALIVE > 0) begin : g_keepalive
        localparam int KA_W = $clog2(KEEPALIVE + 1);
        localparam logic [KA_W-1:0] KA_LAST = KA_W'(KEEPALIVE - 1);
        localparam logic [KA_W-1:0] KA_ONE  = KA_W'(1);

        logic [KA_W-1:0] ka_cnt;

        assign ka_fire = (ka_cnt == KA_LAST);

        // Count idle cycles since the last send or keepalive request
        always_ff @(posedge clk_10k or posedge rst) begin
            if (rst) begin
                ka_cnt <= '0;
            end else if (send_now || ka_fire) begin
                ka_cnt <= '0;
            end else begin
                ka_cnt <= ka_cnt + KA_ONE;
            end
        end
    end else begin : g_no_keepalive
        assign ka_fire = 1'b0;
    end

    // Command byte, handshake strobes and pending flag
    always_ff @(posedge clk_10k or posedge rst) begin
        if (rst) begin
            command <= CMD_DEFAULT;
            send    <= 1'b0;
            key_err <= 1'b0;
            pending <= 1'b0;
        end else begin
            send    <= send_now;
            key_err <= accept && !key_mapped;
            if (accept_mapped) begin
                command <= decoded.command;
            end
            // A new request (key or keepalive) wins over the clear from a send
            if (accept_mapped || ka_fire) begin
                pending <= 1'b1;
            end else if (send_now) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_command_encoder.sv
// Directed bench for keypad_command_encoder. Two instances share the clock:
// dut with default parameters (keepalive far beyond the run length between
// resets) and dut_ka with KEEPALIVE=50 for the keepalive spacing checks.
// Expected sends and key errors are queued with the cycle they must appear.
module tb_keypad_command_encoder;

    logic       clk_10k = 1'b0;
    always #5 clk_10k = ~clk_10k;

    // Main instance signals
    logic       rst = 1'b1;
    logic [3:0] key = 4'd0;
    logic       key_valid = 1'b0;
    logic       tx_ready = 1'b0;
    logic [7:0] command;
    logic       send;
    logic       key_err;
    logic       pending;

    // Keepalive instance signals
    logic       k_rst = 1'b1;
    logic [3:0] k_key = 4'd0;
    logic       k_key_valid = 1'b0;
    logic       k_tx_ready = 1'b0;
    logic [7:0] k_command;
    logic       k_send;
    logic       k_key_err;
    logic       k_pending;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    int         exp_cyc_q[$];
    int         err_cyc_q[$];
    logic [7:0] ka_exp_q[$];
    int         ka_cyc_q[$];

    keypad_command_encoder dut (
        .clk_10k   (clk_10k),
        .rst       (rst),
        .key       (key),
        .key_valid (key_valid),
        .tx_ready  (tx_ready),
        .command   (command),
        .send      (send),
        .key_err   (key_err),
        .pending   (pending)
    );

    keypad_command_encoder #(.KEEPALIVE(50)) dut_ka (
        .clk_10k   (clk_10k),
        .rst       (k_rst),
        .key       (k_key),
        .key_valid (k_key_valid),
        .tx_ready  (k_tx_ready),
        .command   (k_command),
        .send      (k_send),
        .key_err   (k_key_err),
        .pending   (k_pending)
    );

    // Clock-edge counter; read on falling edges only
    always @(posedge clk_10k) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk_10k);
    endtask

    task automatic do_reset();
        @(negedge clk_10k);
        rst = 1'b1;
        key_valid = 1'b0;
        tx_ready = 1'b0;
        key = 4'd0;
        repeat (3) @(negedge clk_10k);
        check("rst_command", int'(command), 'h80);
        check("rst_send", int'(send), 0);
        check("rst_key_err", int'(key_err), 0);
        check("rst_pending", int'(pending), 0);
        rst = 1'b0;
    endtask

    // Monitor for the main instance: every send / key_err must match the queue head
    always @(negedge clk_10k) begin : mon_main
        logic [7:0] e;
        int         c;
        if (!rst) begin
            if (send) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL send_unexpected cycle=%0d command=%h required=no send", cyc, command);
                end else begin
                    e = exp_q.pop_front();
                    c = exp_cyc_q.pop_front();
                    if (command !== e || cyc != c) begin
                        failures++;
                        $display("FAIL send_match actual=%h@%0d required=%h@%0d", command, cyc, e, c);
                    end
                end
            end
            if (key_err) begin
                checks++;
                if (err_cyc_q.size() == 0) begin
                    failures++;
                    $display("FAIL key_err_unexpected cycle=%0d", cyc);
                end else begin
                    c = err_cyc_q.pop_front();
                    if (cyc != c) begin
                        failures++;
                        $display("FAIL key_err_match actual=@%0d required=@%0d", cyc, c);
                    end
                end
            end
        end
    end

    // Monitor for the keepalive instance
    always @(negedge clk_10k) begin : mon_ka
        logic [7:0] e;
        int         c;
        if (!k_rst) begin
            if (k_send) begin
                checks++;
                if (ka_exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL ka_send_unexpected cycle=%0d command=%h required=no send", cyc, k_command);
                end else begin
                    e = ka_exp_q.pop_front();
                    c = ka_cyc_q.pop_front();
                    if (k_command !== e || cyc != c) begin
                        failures++;
                        $display("FAIL ka_send_match actual=%h@%0d required=%h@%0d", k_command, cyc, e, c);
                    end
                end
            end
            if (k_key_err) begin
                checks++;
                failures++;
                $display("FAIL ka_key_err_unexpected cycle=%0d", cyc);
            end
        end
    end

    // Hard time limit in case something stalls
    initial begin
        #2000000;
        $display("FAIL watchdog cycle=%0d required=finish", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    logic [3:0] seq_key [5] = '{4'd10, 4'd13, 4'd9, 4'd6, 4'd14};
    logic [7:0] seq_cmd [5] = '{8'h84, 8'h94, 8'h90, 8'h92, 8'h80};

    initial begin
        int t0;
        int r;

        // Test 1: key 6 held 30 cycles, command on edge 22, send on 23
        do_reset();
        tx_ready = 1'b1;
        t0 = cyc;
        exp_q.push_back(8'h82); exp_cyc_q.push_back(t0 + 23);
        key = 4'd6; key_valid = 1'b1;
        wait_cyc(t0 + 21); check("t1_cmd_before", int'(command), 'h80);
        wait_cyc(t0 + 22); check("t1_cmd_update", int'(command), 'h82);
        check("t1_pending_set", int'(pending), 1);
        wait_cyc(t0 + 23); check("t1_pending_clear", int'(pending), 0);
        wait_cyc(t0 + 30); key_valid = 1'b0;
        wait_cyc(t0 + 45); check("t1_drained", exp_q.size(), 0);

        // Test 2: short glitches (10 and 19 cycles) rejected, 20 accepted
        do_reset();
        tx_ready = 1'b1;
        t0 = cyc; key = 4'd5; key_valid = 1'b1;
        wait_cyc(t0 + 10); key_valid = 1'b0;
        wait_cyc(t0 + 40);
        check("t2_glitch10_cmd", int'(command), 'h80);
        check("t2_glitch10_pending", int'(pending), 0);
        t0 = cyc; key = 4'd6; key_valid = 1'b1;
        wait_cyc(t0 + 19); key_valid = 1'b0;
        wait_cyc(t0 + 40);
        check("t2_glitch19_cmd", int'(command), 'h80);
        t0 = cyc;
        exp_q.push_back(8'h82); exp_cyc_q.push_back(t0 + 23);
        key_valid = 1'b1;
        wait_cyc(t0 + 20); key_valid = 1'b0;
        wait_cyc(t0 + 22); check("t2_pulse20_cmd", int'(command), 'h82);
        wait_cyc(t0 + 40); check("t2_drained", exp_q.size(), 0);

        // Test 3: tx_ready low, two keys coalesce into one send
        do_reset();
        tx_ready = 1'b0;
        t0 = cyc; key = 4'd8; key_valid = 1'b1;
        wait_cyc(t0 + 25); key_valid = 1'b0;
        wait_cyc(t0 + 30);
        check("t3_cmd_left", int'(command), 'h88);
        check("t3_pending_1", int'(pending), 1);
        t0 = cyc; key = 4'd12; key_valid = 1'b1;
        wait_cyc(t0 + 25); key_valid = 1'b0;
        wait_cyc(t0 + 30);
        check("t3_cmd_mode", int'(command), 'hA8);
        check("t3_pending_2", int'(pending), 1);
        t0 = cyc;
        exp_q.push_back(8'hA8); exp_cyc_q.push_back(t0 + 1);
        tx_ready = 1'b1;
        wait_cyc(t0 + 1); check("t3_pending_clear", int'(pending), 0);
        wait_cyc(t0 + 10); check("t3_drained", exp_q.size(), 0);

        // Test 4: unmapped key 3 gives one key_err, nothing else
        do_reset();
        tx_ready = 1'b1;
        t0 = cyc;
        err_cyc_q.push_back(t0 + 22);
        key = 4'd3; key_valid = 1'b1;
        wait_cyc(t0 + 30); key_valid = 1'b0;
        wait_cyc(t0 + 40);
        check("t4_cmd", int'(command), 'h80);
        check("t4_pending", int'(pending), 0);
        check("t4_err_drained", err_cyc_q.size(), 0);

        // Test 5: steer/direction/speed/reset keys in sequence
        do_reset();
        tx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            t0 = cyc;
            exp_q.push_back(seq_cmd[i]); exp_cyc_q.push_back(t0 + 23);
            key = seq_key[i]; key_valid = 1'b1;
            wait_cyc(t0 + 25); key_valid = 1'b0;
            wait_cyc(t0 + 30);
            check($sformatf("t5_key%0d_cmd", seq_key[i]), int'(command), int'(seq_cmd[i]));
        end
        check("t5_drained", exp_q.size(), 0);

        // Test 6: reset during COUNT with key 13 held, then one clean accept
        do_reset();
        tx_ready = 1'b1;
        t0 = cyc; key = 4'd13; key_valid = 1'b1;
        wait_cyc(t0 + 10);
        rst = 1'b1;
        wait_cyc(t0 + 13);
        check("t6_rst_cmd", int'(command), 'h80);
        check("t6_rst_pending", int'(pending), 0);
        rst = 1'b0;
        r = cyc;
        exp_q.push_back(8'h90); exp_cyc_q.push_back(r + 23);
        wait_cyc(r + 21); check("t6_cmd_before", int'(command), 'h80);
        wait_cyc(r + 22); check("t6_cmd_update", int'(command), 'h90);
        wait_cyc(r + 30); key_valid = 1'b0;
        wait_cyc(r + 45); check("t6_drained", exp_q.size(), 0);

        // Test 7: keepalive every 51 cycles; a key send restarts the spacing
        @(negedge clk_10k);
        k_tx_ready = 1'b1;
        k_rst = 1'b0;
        r = cyc;
        ka_exp_q.push_back(8'h80); ka_cyc_q.push_back(r + 51);
        ka_exp_q.push_back(8'h80); ka_cyc_q.push_back(r + 102);
        ka_exp_q.push_back(8'h80); ka_cyc_q.push_back(r + 153);
        ka_exp_q.push_back(8'h81); ka_cyc_q.push_back(r + 183);
        ka_exp_q.push_back(8'h81); ka_cyc_q.push_back(r + 234);
        ka_exp_q.push_back(8'h81); ka_cyc_q.push_back(r + 285);
        wait_cyc(r + 160);
        k_key = 4'd5; k_key_valid = 1'b1;
        wait_cyc(r + 190); k_key_valid = 1'b0;
        wait_cyc(r + 300);
        check("t7_ka_cmd", int'(k_command), 'h81);
        check("t7_ka_drained", ka_exp_q.size(), 0);

        check("final_send_q_empty", exp_q.size(), 0);
        check("final_err_q_empty", err_cyc_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
